// File: rtl/tram_pkg.sv
// Shared widths, FSM state encoding and round-robin history encoding for the
// tag RAM controller.
package tram_pkg;

    localparam int TRAM_DATA_W = 54;
    localparam int TRAM_ADDR_W = 9;
    localparam int TRAM_DEPTH  = 512;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // Which port won the most recent contested cycle.
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } rr_t;

endpackage

// File: rtl/tram_if.sv
// Requester-side handshake bundle of the tag RAM controller: lookup port,
// update port, flush and init status.
interface tram_if
    import tram_pkg::*;
#(
    parameter int DATA_W = TRAM_DATA_W,
    parameter int ADDR_W = TRAM_ADDR_W
) ();

    logic              flush_req;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic              init_done;

    modport master (
        output flush_req, rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_valid, rd_data, wr_gnt, init_done
    );

    modport slave (
        input  flush_req, rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_valid, rd_data, wr_gnt, init_done
    );

endinterface

// File: rtl/tram_rr_arb.sv
// Two-way round-robin arbiter: req[0] = lookup, req[1] = update.
// History only moves on contested cycles, so a lone requester never loses its turn.
module tram_rr_arb
    import tram_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    rr_t rr_last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr_last == WRITE) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last <= WRITE;
        end else if (en && (req == 2'b11)) begin
            rr_last <= gnt[0] ? READ : WRITE;
        end
    end

endmodule

// File: rtl/tram_ctrl.sv
// Tag RAM sequencer: zero-sweeps t_ram after reset or flush, then arbitrates the
// lookup and update ports onto the single RAM port.
//
//   state  | meaning
//   S_RST  | held in / just out of reset, RAM port idle
//   S_INIT | writing zero to entry cnt, requests blocked
//   S_RUN  | RAM cleared, one grant per cycle via round-robin
module tram_ctrl
    import tram_pkg::*;
#(
    parameter int DATA_W = TRAM_DATA_W,
    parameter int ADDR_W = TRAM_ADDR_W,
    parameter int DEPTH  = TRAM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    tram_if.slave             bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_wd,
    input  logic [DATA_W-1:0] ram_rd
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              arb_en;
    logic [1:0]        gnt;

    // A flush in S_RUN outranks both requesters for that cycle.
    assign arb_en = (state == S_RUN) && !bus.flush_req;

    tram_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({bus.wr_req, bus.rd_req}),
        .en    (arb_en),
        .gnt   (gnt)
    );

    assign bus.rd_gnt = gnt[0];
    assign bus.wr_gnt = gnt[1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ram_addr  = '0;
        ram_wr    = 1'b0;
        ram_wd    = '0;
        case (state)
            S_RST: state_nxt = S_INIT;
            S_INIT: begin
                ram_wr   = 1'b1;
                ram_addr = cnt;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            S_RUN: begin
                if (bus.flush_req) begin
                    state_nxt = S_INIT;
                    cnt_nxt   = '0;
                end else if (gnt[1]) begin
                    ram_wr   = 1'b1;
                    ram_addr = bus.wr_addr;
                    ram_wd   = bus.wr_data;
                end else if (gnt[0]) begin
                    ram_addr = bus.rd_addr;
                end
            end
            default: state_nxt = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_RST;
            cnt           <= '0;
            bus.init_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            bus.init_done <= (state_nxt == S_RUN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= gnt[0];
            if (gnt[0]) begin
                bus.rd_data <= ram_rd;
            end
        end
    end

endmodule

// File: doc/tram_ctrl.md
Name: tram_ctrl

Overview:
- Sequencer and arbiter in front of the single-port tag RAM t_ram (54-bit entries, 9-bit address, 512 deep).
- Two requesters share the one RAM port: a lookup (read) port from the cache pipeline and an update (write) port from the fill/invalidate logic.
- On reset release, and on a flush request, the block sweeps the whole RAM and writes zero to every entry. Requests are blocked until the sweep completes.

Parameters:
- DATA_W, 54, tag entry width
- ADDR_W, 9, RAM address width
- DEPTH, 512, number of entries (DEPTH <= 2**ADDR_W)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- flush_req  in  1  single-cycle pulse: invalidate the whole RAM
- rd_req  in  1  lookup request; held with rd_addr until rd_gnt
- rd_addr  in  ADDR_W  lookup address
- rd_gnt  out  1  lookup accepted this cycle (combinational)
- rd_valid  out  1  rd_data valid; registered, one cycle after rd_gnt
- rd_data  out  DATA_W  captured lookup data
- wr_req  in  1  update request; held with wr_addr/wr_data until wr_gnt
- wr_addr  in  ADDR_W  update address
- wr_data  in  DATA_W  update data
- wr_gnt  out  1  update accepted; RAM written at the end of this cycle
- init_done  out  1  1 = RAM cleared, requests serviceable
- ram_addr  out  ADDR_W  to t_ram.ram_addr
- ram_wr  out  1  to t_ram.wr
- ram_wd  out  DATA_W  to t_ram.wd
- ram_rd  in  DATA_W  from t_ram.rd (combinational read of ram_addr)

Behaviour:
- RAM model: write is synchronous (posedge, when ram_wr=1); read is combinational from ram_addr.
- States are S_RST, S_INIT, S_RUN. Reset value is S_RST with sweep counter cnt = 0.
- Reset values: rd_valid = 0, rd_data = 0, init_done = 0, rr_last = WRITE (so a read wins the first contest).
- S_RST:
  - All combinational outputs are 0: ram_wr, ram_addr, ram_wd, rd_gnt, wr_gnt.
  - Moves to S_INIT on the first posedge after reset deasserts.
- S_INIT:
  - Drives ram_wr = 1, ram_addr = cnt, ram_wd = 0; cnt increments each cycle.
  - When cnt == DEPTH-1, goes to S_RUN and clears cnt. A full sweep is exactly DEPTH cycles.
  - rd_gnt = wr_gnt = 0 and init_done = 0 throughout; flush_req is ignored.
- S_RUN:
  - init_done = 1. At most one grant per cycle.
  - Only rd_req set: rd_gnt = 1, ram_addr = rd_addr, ram_wr = 0.
  - Only wr_req set: wr_gnt = 1, ram_addr = wr_addr, ram_wd = wr_data, ram_wr = 1.
  - Both set: round-robin. Grant the port that did not win the previous contested cycle, then update rr_last. Uncontested grants do not update rr_last. Worst-case wait is 1 cycle.
  - No grant: ram_addr = 0, ram_wr = 0, ram_wd = 0.
- Read return:
  - On the posedge ending a rd_gnt cycle: rd_data <= ram_rd, rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its value.
  - Read latency is 1 cycle.
  - A write granted in cycle N is visible to a read granted in cycle N+1 or later.
- Flush:
  - flush_req = 1 in S_RUN takes priority over both requests that cycle: no grants, and ram_wr = 0 that cycle.
  - Next state is S_INIT with cnt = 0 and init_done dropping to 0.
  - A rd_valid pending from the previous cycle's grant is still delivered.
- Asynchronous reset mid-sweep or mid-run: returns immediately to S_RST. rd_valid, init_done and cnt clear, and a full sweep restarts from address 0.
- Requesters must not drop a request before its grant. Behaviour when req changes without a grant is undefined.

Decomposition:
- Package tram_pkg holds:
  - DATA_W, ADDR_W, DEPTH defaults
  - the state encoding (S_RST, S_INIT, S_RUN)
  - the rr_last encoding (READ/WRITE)
- Sub-module tram_rr_arb: 2-way round-robin arbiter with inputs req[1:0], en and outputs gnt[1:0], plus the rr_last register.
- The FSM, sweep counter and RAM mux stay in tram_ctrl.

Test Plan:
1. Reset release with a DEPTH=8 instance: ram_wr = 1 for 8 cycles at addresses 0..7 with wd = 0; init_done rises on the 9th cycle after S_RST exits; no grants while init_done = 0.
2. wr_req at addr 0x005 with data 0x3_FFFF_0000_1234, then rd_req at addr 0x005: wr_gnt in cycle N, rd_gnt in N+1, rd_valid = 1 in N+2 with rd_data = 0x3_FFFF_0000_1234.
3. rd_req and wr_req both held for 4 cycles: grants alternate rd, wr, rd, wr; every rd_gnt is followed by rd_valid on the next cycle.
4. flush_req with wr_req asserted in the same cycle: no wr_gnt; a DEPTH-cycle zero sweep follows; after init_done, a read of the previously written address returns 0.
5. reset pulled low at sweep address 3, then released: outputs clear immediately; the sweep restarts at address 0 and takes the full DEPTH cycles.
6. Read of address 511 (DEPTH=512) after a write of 0x2A at 511: rd_data = 0x2A, confirming the top-of-range address is handled without wrap.
